// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral on the data-memory port.
// Prescaled 32-bit counter with compare match, overflow, sticky status and IRQ level.
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    output logic [31:0] rdata,
    output logic        rd_hit,
    output logic        irq
);

    typedef enum logic [2:0] {
        OFF_CTRL     = 3'd0,
        OFF_PRESCALE = 3'd1,
        OFF_COMPARE  = 3'd2,
        OFF_COUNT    = 3'd3,
        OFF_STATUS   = 3'd4
    } reg_off_e;

    localparam logic [26:0] BASE_TAG = BASE_ADDR[31:5];

    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]           compare_q, compare_d;
    logic [31:0]           count_q, count_d;
    logic                  match_q, match_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rd_hit_q;

    logic       hit, wr, tick, set_match, set_ovf;
    logic [2:0] off;
    logic       unused_addr_lsb;

    assign unused_addr_lsb = ^addr[1:0];

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        hit        = (addr[31:5] == BASE_TAG);
        off        = addr[4:2];
        wr         = hit & mem_write;
        tick       = ctrl_q[0] && (pre_cnt_q == prescale_q);

        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        set_match  = 1'b0;
        set_ovf    = 1'b0;
        rdata_d    = 32'h0;

        if (wr && (off == OFF_CTRL || off == OFF_PRESCALE)) begin
            pre_cnt_d = '0;
        end else if (!ctrl_q[0] || tick) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end

        // A software COUNT write wins over a tick and suppresses match/overflow evaluation.
        if (wr && off == OFF_COUNT) begin
            count_d = wdata;
        end else if (tick) begin
            set_match = (count_q == compare_q);
            if (set_match && ctrl_q[1]) begin
                count_d = 32'h0;
            end else begin
                count_d = count_q + 32'd1;
                set_ovf = &count_q;
            end
        end

        match_d = (match_q & ~(wr && off == OFF_STATUS && wdata[0])) | set_match;
        ovf_d   = (ovf_q   & ~(wr && off == OFF_STATUS && wdata[1])) | set_ovf;

        if (wr) begin
            case (off)
                OFF_CTRL:     ctrl_d     = wdata[2:0];
                OFF_PRESCALE: prescale_d = wdata[PRESCALE_W-1:0];
                OFF_COMPARE:  compare_d  = wdata;
                default:      ;
            endcase
        end

        if (hit) begin
            case (off)
                OFF_CTRL:     rdata_d = {29'h0, ctrl_q};
                OFF_PRESCALE: rdata_d = 32'(prescale_q);
                OFF_COMPARE:  rdata_d = compare_q;
                OFF_COUNT:    rdata_d = count_q;
                OFF_STATUS:   rdata_d = {30'h0, ovf_q, match_q};
                default:      rdata_d = 32'h0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            compare_q  <= '0;
            count_q    <= '0;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rdata_q    <= '0;
            rd_hit_q   <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
            rdata_q    <= rdata_d;
            rd_hit_q   <= hit;
        end
    end

    assign rdata  = rdata_q;
    assign rd_hit = rd_hit_q;
    assign irq    = ctrl_q[2] & (match_q | ovf_q);

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral on the processor data-memory port, beside the data RAM.
- Consumes the store traffic the core sends to memory: ALU address, register-file write data and the memory write strobe.
- Returns read data with the same one-cycle latency as the synchronous data RAM, so the core's memory-to-register path can select it.
- Drives an interrupt-request level for future exception support.

Parameters:
BASE_ADDR, 32'h0000_0400, byte base address of the register window; must be 32-byte aligned
PRESCALE_W, 16, width of prescaler register and prescale counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
addr  input  32  byte address from the core ALU result
wdata  input  32  store data from the core register file
mem_write  input  1  store strobe from the core control unit
rdata  output  32  registered read data, valid one cycle after address
rd_hit  output  1  registered flag: the address of the previous cycle hit this block; core muxes rdata vs RAM data
irq  output  1  interrupt request level

Behaviour:
- Reset (rst=0, asynchronous): every register, counter, rdata, rd_hit and irq at 0.
- Address decode:
  - hit = (addr[31:5] == BASE_ADDR[31:5]).
  - Offset = addr[4:2]; addr[1:0] ignored.
  - Writes occur when hit & mem_write.
- Register map (word offsets):
  - 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0]; upper bits read 0.
  - 0x08 COMPARE: 32-bit.
  - 0x0C COUNT: 32-bit, R/W.
  - 0x10 STATUS: bit0 match, bit1 overflow; sticky, write-1-to-clear.
  - 0x14-0x1C: read 0, writes ignored.
- Read path:
  - rdata and rd_hit are registered every cycle from the current addr/hit.
  - rdata returns register values before that same edge's updates (read-old).
  - Non-hit cycles: rdata=0, rd_hit=0.
  - No read strobe; reads have no side effects.
- Prescaler:
  - pre_cnt counts 0..PRESCALE while enable=1.
  - tick asserted in the cycle pre_cnt==PRESCALE; pre_cnt then returns to 0.
  - PRESCALE=0: tick every enabled cycle.
  - enable=0: pre_cnt held at 0 and no ticks.
  - Any write to PRESCALE or CTRL clears pre_cnt.
- Counter on tick:
  - COUNT==COMPARE: set match; COUNT <= auto_reload ? 0 : COUNT+1, using 32-bit wrap.
  - Otherwise COUNT <= COUNT+1.
  - overflow set whenever the increment wraps FFFF_FFFF->0. With auto_reload and COMPARE=FFFF_FFFF, the reload is not an overflow.
- Simultaneous events:
  - A software write to COUNT beats a tick in the same cycle: the written value is loaded, and no match/overflow is evaluated that cycle.
  - STATUS W1C in the same cycle as a hardware set: the set wins and the bit stays 1.
  - Writing COMPARE takes effect for the next tick's comparison.
- irq = irq_en & (match | overflow), decoded from flops with no combinational input path.
- Reset mid-operation: all state cleared immediately; counting resumes only after software rewrites CTRL.

Test Plan:
- Reset/readback: rst low then high; read 0x00-0x1C -> all rdata=0. Write COMPARE=0x1234 -> read one cycle later gives 0x0000_1234, rd_hit=1. Address BASE+0x40 -> rd_hit=0.
- Prescaled count: PRESCALE=3, COUNT=0, CTRL=1, run 40 cycles -> COUNT=10, one increment every 4 cycles.
- Auto-reload match/irq: PRESCALE=0, COMPARE=5, CTRL=0x7 -> sequence 0,1,2,3,4,5,0. match=1 and irq=1 after the 6th tick. Write STATUS=1 -> match=0, irq=0. Next match sets it again.
- Overflow: COUNT=FFFF_FFFE, COMPARE=0, CTRL=1, PRESCALE=0 -> after two ticks COUNT=0, overflow=1, match=0. Then one tick later COUNT=1 and match=1.
- Collisions:
  - Write COUNT=0x50 on a tick cycle -> COUNT=0x50, not 0x51.
  - W1C on STATUS in the cycle a match occurs -> match remains 1.
- Async reset mid-count: drop rst between clock edges while counting -> COUNT, STATUS, irq, rdata are 0 before the next edge. After release with no writes, COUNT stays 0.
